// File: rtl/crypt_selftest_pkg.sv
// Shared types and helpers for the crypto known-answer-test sequencer.
package crypt_selftest_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        WAIT,
        CHECK,
        NEXT,
        FIN
    } state_e;

    // True when the vector count is legal and its index fits the address width.
    function automatic bit idx_width_ok(input int num_vectors, input int idx_width);
        return (num_vectors >= 1) && (num_vectors <= 256) &&
               ($clog2(num_vectors) <= idx_width);
    endfunction

endpackage

// File: rtl/crypt_selftest_tmo.sv
// Per-vector timeout counter: cleared while the core is started, counts while
// waiting, and flags expiry on the cycle the count reaches pTIMEOUT.
module crypt_selftest_tmo
    import crypt_selftest_pkg::*;
#(
    parameter int pTIMEOUT = 1023
) (
    input  logic crypto_clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(pTIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired_o = en_i && (cnt_q == CNT_W'(pTIMEOUT - 1));

    always_comb begin
        // NOTE: next-state defaults to the held value first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge crypto_clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/crypt_selftest_seq.sv
// Known-answer-test sequencer: walks pNUM_VECTORS ROM entries through the core.
// Define SELFTEST_FAILLOG_EN to add fail_ct/fail_exp capture of the first mismatch.
module crypt_selftest_seq
    import crypt_selftest_pkg::*;
#(
    parameter int pPT_WIDTH    = 128,
    parameter int pKEY_WIDTH   = 128,
    parameter int pCT_WIDTH    = 128,
    parameter int pNUM_VECTORS = 4,
    parameter int pTIMEOUT     = 1023,
    parameter int pIDX_WIDTH   = 8
) (
    input  logic                  crypto_clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  abort,
    output logic [pIDX_WIDTH-1:0] vec_addr,
    input  logic [pPT_WIDTH-1:0]  vec_pt,
    input  logic [pKEY_WIDTH-1:0] vec_key,
    input  logic [pCT_WIDTH-1:0]  vec_ct,
    output logic [pPT_WIDTH-1:0]  core_pt,
    output logic [pKEY_WIDTH-1:0] core_key,
    output logic                  core_start,
    input  logic                  core_done,
    input  logic [pCT_WIDTH-1:0]  core_ct,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [pIDX_WIDTH:0]   fail_count,
    output logic [pIDX_WIDTH-1:0] first_fail_idx,
    output logic                  timeout_flag,
    output logic                  aborted
`ifdef SELFTEST_FAILLOG_EN
    ,
    output logic [pCT_WIDTH-1:0]  fail_ct,
    output logic [pCT_WIDTH-1:0]  fail_exp
`endif
);

    localparam logic [pIDX_WIDTH-1:0] LAST_IDX = pIDX_WIDTH'(pNUM_VECTORS - 1);

    if (!idx_width_ok(pNUM_VECTORS, pIDX_WIDTH)) begin : g_bad_cfg
        $error("crypt_selftest_seq: pNUM_VECTORS out of range for pIDX_WIDTH");
    end

    state_e                  state_q;
    logic [pIDX_WIDTH-1:0]   idx_q;
    logic [pIDX_WIDTH-1:0]   ffi_q;
    logic [pIDX_WIDTH:0]     fail_q;
    logic [pPT_WIDTH-1:0]    core_pt_q;
    logic [pKEY_WIDTH-1:0]   core_key_q;
    logic [pCT_WIDTH-1:0]    exp_q;
    logic [pCT_WIDTH-1:0]    ct_q;
    logic                    start_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    pass_q;
    logic                    tmo_flag_q;
    logic                    aborted_q;
`ifdef SELFTEST_FAILLOG_EN
    logic [pCT_WIDTH-1:0]    fail_ct_q;
    logic [pCT_WIDTH-1:0]    fail_exp_q;
    logic                    log_vld_q;
`endif

    logic                    tmo_expired;
    logic                    fin_abort;
    logic                    fin_entry;
    logic [pIDX_WIDTH:0]     fail_inc;

    crypt_selftest_tmo #(
        .pTIMEOUT (pTIMEOUT)
    ) u_tmo (
        .crypto_clk (crypto_clk),
        .reset      (reset),
        .clr_i      (state_q == START),
        .en_i       (state_q == WAIT),
        .expired_o  (tmo_expired)
    );

    assign fail_inc = (&fail_q) ? fail_q : fail_q + 1'b1;

    // Abort is honoured only at state boundaries; a done in WAIT completes the vector first.
    always_comb begin
        fin_abort = abort && ((state_q == FETCH) || (state_q == NEXT) ||
                              ((state_q == WAIT) && !core_done));
        fin_entry = fin_abort || ((state_q == NEXT) && (idx_q == LAST_IDX));
    end

    always_ff @(posedge crypto_clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            ffi_q      <= '0;
            fail_q     <= '0;
            core_pt_q  <= '0;
            core_key_q <= '0;
            exp_q      <= '0;
            ct_q       <= '0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            tmo_flag_q <= 1'b0;
            aborted_q  <= 1'b0;
`ifdef SELFTEST_FAILLOG_EN
            fail_ct_q  <= '0;
            fail_exp_q <= '0;
            log_vld_q  <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (run) begin
                        state_q    <= FETCH;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                        fail_q     <= '0;
                        ffi_q      <= '0;
                        tmo_flag_q <= 1'b0;
                        aborted_q  <= 1'b0;
                        idx_q      <= '0;
`ifdef SELFTEST_FAILLOG_EN
                        fail_ct_q  <= '0;
                        fail_exp_q <= '0;
                        log_vld_q  <= 1'b0;
`endif
                    end
                end
                FETCH: state_q <= fin_abort ? FIN : LOAD;
                LOAD: begin
                    core_pt_q  <= vec_pt;
                    core_key_q <= vec_key;
                    exp_q      <= vec_ct;
                    start_q    <= 1'b1;
                    state_q    <= START;
                end
                START: state_q <= WAIT;
                WAIT: begin
                    if (core_done) begin
                        ct_q    <= core_ct;
                        state_q <= CHECK;
                    end else if (fin_abort) begin
                        state_q <= FIN;
                    end else if (tmo_expired) begin
                        tmo_flag_q <= 1'b1;
                        fail_q     <= fail_inc;
                        if (fail_q == '0) ffi_q <= idx_q;
                        state_q    <= NEXT;
                    end
                end
                CHECK: begin
                    if (ct_q != exp_q) begin
                        fail_q <= fail_inc;
                        if (fail_q == '0) ffi_q <= idx_q;
`ifdef SELFTEST_FAILLOG_EN
                        if (!log_vld_q) begin
                            fail_ct_q  <= ct_q;
                            fail_exp_q <= exp_q;
                            log_vld_q  <= 1'b1;
                        end
`endif
                    end
                    state_q <= NEXT;
                end
                NEXT: begin
                    if (fin_entry) begin
                        state_q <= FIN;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= FETCH;
                    end
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            // Status outputs are registered on entry to FIN so they are valid during FIN.
            if (fin_entry) begin
                busy_q    <= 1'b0;
                done_q    <= 1'b1;
                aborted_q <= fin_abort;
                pass_q    <= !fin_abort && (fail_q == '0) && !tmo_flag_q;
            end
        end
    end

    assign vec_addr       = idx_q;
    assign core_pt        = core_pt_q;
    assign core_key       = core_key_q;
    assign core_start     = start_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail_count     = fail_q;
    assign first_fail_idx = ffi_q;
    assign timeout_flag   = tmo_flag_q;
    assign aborted        = aborted_q;
`ifdef SELFTEST_FAILLOG_EN
    assign fail_ct        = fail_ct_q;
    assign fail_exp       = fail_exp_q;
`endif

endmodule

// File: tb/tb_crypt_selftest_seq.sv
// Scoreboard bench for crypt_selftest_seq with a synchronous ROM and an XOR core stand-in.
module tb_crypt_selftest_seq;

    localparam int PT_W  = 128;
    localparam int KEY_W = 128;
    localparam int CT_W  = 128;
    localparam int NV    = 4;
    localparam int TMO   = 20;
    localparam int IW    = 8;

    localparam logic [CT_W-1:0] CT2 = 128'h8a278bf8fa2812bc39e52c76205af376;

    typedef struct {
        logic [PT_W-1:0]  pt;
        logic [KEY_W-1:0] key;
        logic [CT_W-1:0]  ct;
    } vec_t;

    typedef struct {
        logic            pass;
        logic [IW:0]     fails;
        logic [IW-1:0]   ffi;
        bit              chk_ffi;
        logic            tmo;
        logic            abrt;
        logic [CT_W-1:0] fct;
        logic [CT_W-1:0] fexp;
    } exp_t;

    typedef struct {
        logic [PT_W-1:0]  pt;
        logic [KEY_W-1:0] key;
    } start_t;

    logic              crypto_clk = 1'b0;
    logic              reset;
    logic              run;
    logic              abort;
    logic [IW-1:0]     vec_addr;
    logic [PT_W-1:0]   vec_pt  = '0;
    logic [KEY_W-1:0]  vec_key = '0;
    logic [CT_W-1:0]   vec_ct  = '0;
    logic [PT_W-1:0]   core_pt;
    logic [KEY_W-1:0]  core_key;
    logic              core_start;
    logic              core_done;
    logic [CT_W-1:0]   core_ct;
    logic              busy;
    logic              done;
    logic              pass;
    logic [IW:0]       fail_count;
    logic [IW-1:0]     first_fail_idx;
    logic              timeout_flag;
    logic              aborted;
`ifdef SELFTEST_FAILLOG_EN
    logic [CT_W-1:0]   fail_ct;
    logic [CT_W-1:0]   fail_exp;
`endif

    vec_t   rom [NV];
    int     dly [NV];
    exp_t   sb[$];
    start_t start_q[$];
    int     total = 0;
    int     bad = 0;
    int     runs_seen = 0;
    int     starts_seen = 0;
    int     busy_cycles = 0;
    logic   done_prev = 1'b0;

    always #5 crypto_clk = ~crypto_clk;

    crypt_selftest_seq #(
        .pPT_WIDTH    (PT_W),
        .pKEY_WIDTH   (KEY_W),
        .pCT_WIDTH    (CT_W),
        .pNUM_VECTORS (NV),
        .pTIMEOUT     (TMO),
        .pIDX_WIDTH   (IW)
    ) dut (
        .crypto_clk     (crypto_clk),
        .reset          (reset),
        .run            (run),
        .abort          (abort),
        .vec_addr       (vec_addr),
        .vec_pt         (vec_pt),
        .vec_key        (vec_key),
        .vec_ct         (vec_ct),
        .core_pt        (core_pt),
        .core_key       (core_key),
        .core_start     (core_start),
        .core_done      (core_done),
        .core_ct        (core_ct),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .fail_count     (fail_count),
        .first_fail_idx (first_fail_idx),
        .timeout_flag   (timeout_flag),
        .aborted        (aborted)
`ifdef SELFTEST_FAILLOG_EN
        ,
        .fail_ct        (fail_ct),
        .fail_exp       (fail_exp)
`endif
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Synchronous vector ROM: data valid one cycle after the address.
    always @(posedge crypto_clk) begin
        if (int'(vec_addr) < NV) begin
            vec_pt  <= rom[int'(vec_addr)].pt;
            vec_key <= rom[int'(vec_addr)].key;
            vec_ct  <= rom[int'(vec_addr)].ct;
        end
    end

    // Core stand-in: ct = pt ^ key, done dly[idx] cycles after start (0 = never).
    initial begin : core_model
        int remaining;
        logic [CT_W-1:0] ct_hold;
        remaining = 0;
        ct_hold   = '0;
        core_done = 1'b0;
        core_ct   = '0;
        forever begin
            @(negedge crypto_clk);
            core_done = 1'b0;
            if (reset) begin
                remaining = 0;
            end else if (core_start) begin
                remaining = dly[int'(vec_addr)];
                ct_hold   = core_pt ^ core_key;
            end else if (remaining > 0) begin
                remaining--;
                if (remaining == 0) begin
                    core_done = 1'b1;
                    core_ct   = ct_hold;
                end
            end
        end
    end

    initial begin : monitor
        start_t s;
        exp_t   e;
        forever begin
            @(negedge crypto_clk);
            if (busy) busy_cycles++;
            if (core_start) begin
                starts_seen++;
                if (start_q.size() == 0) begin
                    check("spurious_start", 1'b1, 1'b0);
                end else begin
                    s = start_q.pop_front();
                    check("core_pt", core_pt, s.pt);
                    check("core_key", core_key, s.key);
                end
            end
            if (done && !done_prev) begin
                runs_seen++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("pass", pass, e.pass);
                    check("fail_count", fail_count, e.fails);
                    if (e.chk_ffi) check("first_fail_idx", first_fail_idx, e.ffi);
                    check("timeout_flag", timeout_flag, e.tmo);
                    check("aborted", aborted, e.abrt);
                    check("busy_at_fin", busy, 1'b0);
`ifdef SELFTEST_FAILLOG_EN
                    check("fail_ct", fail_ct, e.fct);
                    check("fail_exp", fail_exp, e.fexp);
`endif
                end
            end
            done_prev = done;
        end
    end

    function automatic exp_t mk_exp(input logic p, input int fails, input int ffi,
                                    input bit chk_ffi, input logic tmo, input logic abrt);
        exp_t e;
        e.pass    = p;
        e.fails   = (IW+1)'(fails);
        e.ffi     = IW'(ffi);
        e.chk_ffi = chk_ffi;
        e.tmo     = tmo;
        e.abrt    = abrt;
        e.fct     = '0;
        e.fexp    = '0;
        return e;
    endfunction

    task automatic push_starts(input int n);
        start_t s;
        for (int i = 0; i < n; i++) begin
            s.pt  = rom[i].pt;
            s.key = rom[i].key;
            start_q.push_back(s);
        end
    endtask

    task automatic pulse_run();
        @(negedge crypto_clk);
        run = 1'b1;
        @(negedge crypto_clk);
        run = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge crypto_clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, ok, 1'b1);
    endtask

    task automatic wait_starts(input string tag, input int target);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge crypto_clk);
            if (starts_seen >= target) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, ok, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vec_addr"}, vec_addr, '0);
        check({tag, "_core_pt"}, core_pt, '0);
        check({tag, "_core_key"}, core_key, '0);
        check({tag, "_core_start"}, core_start, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_pass"}, pass, 1'b0);
        check({tag, "_fail_count"}, fail_count, '0);
        check({tag, "_ffi"}, first_fail_idx, '0);
        check({tag, "_timeout"}, timeout_flag, 1'b0);
        check({tag, "_aborted"}, aborted, 1'b0);
`ifdef SELFTEST_FAILLOG_EN
        check({tag, "_fail_ct"}, fail_ct, '0);
        check({tag, "_fail_exp"}, fail_exp, '0);
`endif
    endtask

    initial begin : main
        exp_t e;
        int   s0;
        reset = 1'b1;
        run   = 1'b0;
        abort = 1'b0;

        rom[0].pt  = 128'h00112233445566778899aabbccddeeff;
        rom[0].key = 128'h000102030405060708090a0b0c0d0e0f;
        rom[1].pt  = 128'h3243f6a8885a308d313198a2e0370734;
        rom[1].key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rom[2].key = 128'h0123456789abcdeffedcba9876543210;
        rom[2].pt  = CT2 ^ rom[2].key;
        rom[3].pt  = 128'hffffffffffffffffffffffffffffffff;
        rom[3].key = 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a;
        for (int i = 0; i < NV; i++) begin
            rom[i].ct = rom[i].pt ^ rom[i].key;
            dly[i]    = 10;
        end

        repeat (3) @(negedge crypto_clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Clean run: busy 4*15 cycles; extra run pulses mid-run and in FIN are ignored.
        push_starts(NV);
        sb.push_back(mk_exp(1'b1, 0, 0, 1'b1, 1'b0, 1'b0));
        busy_cycles = 0;
        pulse_run();
        repeat (20) @(negedge crypto_clk);
        run = 1'b1;
        @(negedge crypto_clk);
        run = 1'b0;
        wait_done("clean_completes", 200);
        run = 1'b1;
        @(negedge crypto_clk);
        run = 1'b0;
        repeat (5) @(negedge crypto_clk);
        check("clean_busy_cycles", busy_cycles, 60);
        check("fin_run_ignored_busy", busy, 1'b0);
        check("fin_run_ignored_done", done, 1'b1);

        // Corrupted expected ciphertext on vector 2.
        rom[2].ct = CT2 ^ 128'h1;
        push_starts(NV);
        e = mk_exp(1'b0, 1, 2, 1'b1, 1'b0, 1'b0);
        e.fct  = CT2;
        e.fexp = CT2 ^ 128'h1;
        sb.push_back(e);
        pulse_run();
        wait_done("corrupt_completes", 200);
        rom[2].ct = CT2;

        // Vector 1 never completes: abandoned after TMO wait cycles, later vectors still run.
        dly[1] = 0;
        push_starts(NV);
        sb.push_back(mk_exp(1'b0, 1, 0, 1'b0, 1'b1, 1'b0));
        busy_cycles = 0;
        pulse_run();
        wait_done("timeout_completes", 300);
        check("timeout_busy_cycles", busy_cycles, 3 * 15 + 4 + TMO);
        dly[1] = 10;

        // Done arrives on exactly the timeout cycle: completion wins.
        dly[0] = TMO;
        push_starts(NV);
        sb.push_back(mk_exp(1'b1, 0, 0, 1'b1, 1'b0, 1'b0));
        busy_cycles = 0;
        pulse_run();
        wait_done("edge_completes", 300);
        check("edge_busy_cycles", busy_cycles, 3 * 15 + 5 + TMO);
        dly[0] = 10;

        // Abort during vector 1 wait, then a fresh run clears aborted.
        s0 = starts_seen;
        push_starts(2);
        sb.push_back(mk_exp(1'b0, 0, 0, 1'b1, 1'b0, 1'b1));
        pulse_run();
        wait_starts("abort_reaches_vec1", s0 + 2);
        repeat (3) @(negedge crypto_clk);
        abort = 1'b1;
        wait_done("abort_fin_within_2", 2);
        abort = 1'b0;
        push_starts(NV);
        sb.push_back(mk_exp(1'b1, 0, 0, 1'b1, 1'b0, 1'b0));
        pulse_run();
        check("rerun_clears_aborted", aborted, 1'b0);
        check("rerun_clears_done", done, 1'b0);
        wait_done("rerun_completes", 200);

        // Reset mid-wait: everything clears and no start appears until a new run.
        s0 = starts_seen;
        push_starts(1);
        pulse_run();
        wait_starts("rst_reaches_wait", s0 + 1);
        repeat (3) @(negedge crypto_clk);
        reset = 1'b1;
        #1;
        check_all_zero("rst_mid");
        @(negedge crypto_clk);
        @(negedge crypto_clk);
        reset = 1'b0;
        s0 = starts_seen;
        repeat (40) @(negedge crypto_clk);
        check("no_start_after_reset", starts_seen, s0);
        check("no_done_after_reset", done, 1'b0);

        push_starts(NV);
        sb.push_back(mk_exp(1'b1, 0, 0, 1'b1, 1'b0, 1'b0));
        pulse_run();
        wait_done("post_reset_completes", 200);
        repeat (3) @(negedge crypto_clk);

        check("start_queue_drained", start_q.size(), 0);
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crypt_selftest_seq.md
Name: crypt_selftest_seq

Overview:
- Synthesizable on-target known-answer test (KAT) sequencer for CW310 crypto cores.
- Walks pNUM_VECTORS entries of an external vector ROM. For each entry it loads plaintext and key, pulses start, waits for done (with timeout), then compares the ciphertext.
- Sits in the crypto_clk domain beside the AES core. Its status is mirrored into the register block for host readout.
- Generalises the register-driven single-vector check to N vectors, arbitrary widths, a timeout and a fail log.

Parameters:
- pPT_WIDTH, 128, plaintext width in bits
- pKEY_WIDTH, 128, key width in bits
- pCT_WIDTH, 128, ciphertext width in bits
- pNUM_VECTORS, 4, number of ROM entries tested per run (1..256)
- pTIMEOUT, 1023, maximum crypto_clk cycles to wait for done per vector
- pIDX_WIDTH, 8, vector index width (ceil(log2(pNUM_VECTORS)) <= pIDX_WIDTH)

Ports:
- crypto_clk  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- run  in  1  1-cycle pulse; starts a run when idle
- abort  in  1  level; terminates the run at the next state boundary
- vec_addr  out  pIDX_WIDTH  ROM read address
- vec_pt  in  pPT_WIDTH  ROM plaintext; valid 1 cycle after vec_addr
- vec_key  in  pKEY_WIDTH  ROM key; same timing as vec_pt
- vec_ct  in  pCT_WIDTH  ROM expected ciphertext; same timing as vec_pt
- core_pt  out  pPT_WIDTH  plaintext to the core; held stable
- core_key  out  pKEY_WIDTH  key to the core; held stable
- core_start  out  1  1-cycle start pulse to the core
- core_done  in  1  1-cycle pulse from the core; result valid
- core_ct  in  pCT_WIDTH  core ciphertext; sampled when core_done=1
- busy  out  1  run in progress
- done  out  1  sticky; run finished (cleared by the next run)
- pass  out  1  done and zero failures and no timeout and no abort
- fail_count  out  pIDX_WIDTH+1  number of mismatched or timed-out vectors
- first_fail_idx  out  pIDX_WIDTH  index of the first failing vector
- timeout_flag  out  1  sticky; at least one vector timed out
- aborted  out  1  sticky; run terminated by abort

Behaviour:
- Reset values: every output is 0, core_pt and core_key are 0, state is IDLE.
- States and transitions:
  - IDLE: on run, go to FETCH. Entry clears done, pass, fail_count, first_fail_idx, timeout_flag, aborted and the index (0). busy=1 from the cycle after run.
  - FETCH: drive vec_addr=index, go to LOAD.
  - LOAD: capture vec_pt/vec_key into core_pt/core_key and vec_ct into an internal exp register; go to START.
  - START: core_start=1 for exactly one cycle; clear the timeout counter; go to WAIT.
  - WAIT: counter increments each cycle.
    - core_done=1: sample core_ct, go to CHECK.
    - Counter reaches pTIMEOUT without done: set timeout_flag, count a failure, go to NEXT.
    - core_done and timeout in the same cycle: done wins.
  - CHECK: if core_ct != exp, increment fail_count. If this is the first failure, first_fail_idx=index. Go to NEXT.
  - NEXT: if index == pNUM_VECTORS-1, go to FIN; otherwise index+1, go to FETCH.
  - FIN: done=1, pass computed, busy=0, go to IDLE.
- Latency per vector with an immediate-done core: FETCH+LOAD+START+WAIT(k)+CHECK+NEXT = 5+k cycles.
- run while busy is ignored.
- run in the same cycle as FIN is ignored. done stays 1 and a fresh run is required.
- fail_count saturates at all-ones; it never wraps.
- abort:
  - Sampled in FETCH, NEXT and WAIT. WAIT abandons the vector without counting a failure.
  - Goes to FIN with aborted=1 and pass=0.
  - abort in IDLE has no effect.
- core_done outside WAIT is ignored.
- Asynchronous reset mid-run returns to IDLE immediately with all outputs 0. No core_start is emitted after reset deassertion.
- Comparison is full-width equality on pCT_WIDTH bits.

Optional Feature:
- Macro: SELFTEST_FAILLOG_EN.
- Defined:
  - Adds output fail_ct [pCT_WIDTH], which holds core_ct of the first mismatching vector.
  - Adds output fail_exp [pCT_WIDTH], which holds the expected ciphertext of that vector.
  - Both are 0 at reset and at run start. A timeout leaves them unchanged.
- Undefined: neither port exists and no storage is inferred.

Decomposition:
- Package crypt_selftest_pkg holds:
  - the state enum (IDLE, FETCH, LOAD, START, WAIT, CHECK, NEXT, FIN);
  - localparam state width;
  - a helper function for index-width checks.
- Sub-module crypt_selftest_tmo holds the loadable timeout counter: clear, enable, expired at pTIMEOUT.
- Everything else lives in one module.

Test Plan:
- 4 correct vectors; the core model asserts done 10 cycles after start. Run completes with pass=1, fail_count=0, done=1, and busy high for 4*15 cycles.
- Vector 2's ROM ciphertext is corrupted (e.g. expected 128'h8a278bf8fa2812bc39e52c76205af377, model returns ...376). Result: fail_count=1, first_fail_idx=2, pass=0. With SELFTEST_FAILLOG_EN, fail_ct and fail_exp show both values.
- Core model never asserts done on vector 1, with pTIMEOUT=20. Vector 1 is abandoned after 20 WAIT cycles; timeout_flag=1, fail_count=1, and vectors 2 and 3 still run.
- core_done asserted on exactly the timeout cycle. The vector is treated as completed with no timeout_flag.
- abort raised during vector 1's WAIT. FIN follows within 2 cycles with aborted=1, pass=0, fail_count=0; a second run clears aborted.
- Reset asserted mid-WAIT. All outputs read 0, and no core_start occurs until a new run pulse.
